// File: rtl/lc3_mem_arbiter.sv
// LC-3 unified memory arbiter: CPU and debug/loader ports share one
// fixed-latency synchronous memory with round-robin tie breaking.
module lc3_mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  gnt_cpu,
  output logic                  gnt_dbg,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, WAIT, DONE
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  last_dbg_q, last_dbg_d;
  logic                  own_dbg_q, own_dbg_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  pick_dbg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_dbg_q  <= 1'b1;
      own_dbg_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dbg_q  <= last_dbg_d;
      own_dbg_q   <= own_dbg_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_dbg_d  = last_dbg_q;
    own_dbg_d   = own_dbg_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    pick_dbg    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time takes the memory
        pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
        if (cpu_req | dbg_req) begin
          own_dbg_d  = pick_dbg;
          last_dbg_d = pick_dbg;
          we_d       = pick_dbg ? dbg_we    : cpu_we;
          addr_d     = pick_dbg ? dbg_addr  : cpu_addr;
          wdata_d    = pick_dbg ? dbg_wdata : cpu_wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = LAT_M1;
        state_d = (MEM_LATENCY == 1) ? DONE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = DONE;
      end
      DONE: begin
        if (!we_q) begin
          if (own_dbg_q) dbg_rdata_d = mem_rdata;
          else           cpu_rdata_d = mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is forwarded in DONE so it is valid with the pulse
  assign cpu_rdata = cpu_rdata_d;
  assign dbg_rdata = dbg_rdata_d;
  assign cpu_ready = (state_q == DONE) & ~own_dbg_q;
  assign dbg_ack   = (state_q == DONE) &  own_dbg_q;
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign gnt_cpu   = busy & ~own_dbg_q;
  assign gnt_dbg   = busy &  own_dbg_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: latency-1 and latency-3 instances with
// memory models and per-instance completion scoreboards.
module tb_lc3_mem_arbiter;

  typedef struct {
    bit          dbg;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t exp1_q[$];
  exp_t exp3_q[$];

  logic        rst_n, rst3_n;
  logic        c_req, c_we, d_req, d_we;
  logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [15:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        c_rdy, d_ack, m_en, m_we, g_cpu, g_dbg, busy;

  logic        c3_req, c3_we, d3_req, d3_we;
  logic [15:0] c3_addr, c3_wdata, d3_addr, d3_wdata;
  logic [15:0] c3_rdata, d3_rdata, m3_addr, m3_wdata, m3_rdata;
  logic        c3_rdy, d3_ack, m3_en, m3_we, g3_cpu, g3_dbg, busy3;

  logic [15:0] mem1 [0:65535];
  logic [15:0] mem3 [0:65535];
  logic [15:0] p1, p2;

  lc3_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(rst_n),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr),
    .cpu_wdata(c_wdata), .cpu_rdata(c_rdata), .cpu_ready(c_rdy),
    .dbg_req(d_req), .dbg_we(d_we), .dbg_addr(d_addr),
    .dbg_wdata(d_wdata), .dbg_rdata(d_rdata), .dbg_ack(d_ack),
    .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .mem_rdata(m_rdata),
    .gnt_cpu(g_cpu), .gnt_dbg(g_dbg), .busy(busy)
  );

  lc3_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(rst3_n),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr),
    .cpu_wdata(c3_wdata), .cpu_rdata(c3_rdata), .cpu_ready(c3_rdy),
    .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr),
    .dbg_wdata(d3_wdata), .dbg_rdata(d3_rdata), .dbg_ack(d3_ack),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr),
    .mem_wdata(m3_wdata), .mem_rdata(m3_rdata),
    .gnt_cpu(g3_cpu), .gnt_dbg(g3_dbg), .busy(busy3)
  );

  // Latency-1 memory
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem1[m_addr] <= m_wdata;
      else      m_rdata <= mem1[m_addr];
    end
  end

  // Latency-3 memory
  always @(posedge clk) begin
    if (m3_en && m3_we) mem3[m3_addr] <= m3_wdata;
    p1       <= mem3[m3_addr];
    p2       <= p1;
    m3_rdata <= p2;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitors: pop the expected completion whenever a pulse appears
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("mutex1", {31'd0, g_cpu & g_dbg}, 0);
      if (c_rdy || d_ack) begin
        if (exp1_q.size() == 0) begin
          chk("sb1_unexpected", {c_rdy, d_ack}, 0);
        end else begin
          exp_t e;
          e = exp1_q.pop_front();
          chk("sb1_port", {c_rdy, d_ack}, e.dbg ? 32'd1 : 32'd2);
          if (e.rd) chk("sb1_rdata", e.dbg ? d_rdata : c_rdata, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst3_n === 1'b1) begin
      chk("mutex3", {31'd0, g3_cpu & g3_dbg}, 0);
      if (c3_rdy || d3_ack) begin
        if (exp3_q.size() == 0) begin
          chk("sb3_unexpected", {c3_rdy, d3_ack}, 0);
        end else begin
          exp_t e;
          e = exp3_q.pop_front();
          chk("sb3_port", {c3_rdy, d3_ack}, e.dbg ? 32'd1 : 32'd2);
          if (e.rd) chk("sb3_rdata", e.dbg ? d3_rdata : c3_rdata, e.data);
        end
      end
    end
  end

  // One latency-1 transfer, checked cycle by cycle
  task automatic xfer1(input bit dbg, input bit we, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] ex);
    exp1_q.push_back('{dbg, ~we, ex});
    @(posedge clk); #1;
    if (dbg) begin
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      c_req = 1; c_we = we; c_addr = a; c_wdata = wd;
    end
    @(posedge clk); #1;
    chk("acc_en", m_en, 1);
    chk("acc_we", m_we, we);
    chk("acc_addr", m_addr, a);
    if (we) chk("acc_wdata", m_wdata, wd);
    chk("acc_gnt", dbg ? g_dbg : g_cpu, 1);
    @(posedge clk); #1;
    chk("done_pulse", dbg ? d_ack : c_rdy, 1);
    chk("done_other", dbg ? c_rdy : d_ack, 0);
    chk("done_en", m_en, 0);
    @(posedge clk); #1;
    c_req = 0; d_req = 0;
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem1[16'h3000] = 16'h1234;
    mem3[16'h3000] = 16'h1234;
    rst_n = 0; rst3_n = 0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
    d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", {m_en, m_we, c_rdy, d_ack}, 0);
    chk("rst_gnt", {g_cpu, g_dbg, busy}, 0);
    chk("rst_rdata", {c_rdata, d_rdata}, 0);
    chk("rst_addr", {m_addr, m_wdata}, 0);
    rst_n = 1; rst3_n = 1;

    // Basic CPU read, debug write, CPU read-back, top-of-memory address
    xfer1(0, 0, 16'h3000, 16'h0000, 16'h1234);
    xfer1(1, 1, 16'h3001, 16'hBEEF, 16'h0000);
    xfer1(0, 0, 16'h3001, 16'h0000, 16'hBEEF);
    chk("dbg_rdata_keep", d_rdata, 16'h0000);
    chk("cpu_rdata_hold", c_rdata, 16'hBEEF);
    xfer1(0, 1, 16'hFFFF, 16'hA5A5, 16'h0000);
    chk("cpu_rdata_wr_keep", c_rdata, 16'hBEEF);
    xfer1(0, 0, 16'hFFFF, 16'h0000, 16'hA5A5);

    // CPU drops request and address after grant
    exp1_q.push_back('{0, 1, 16'h1234});
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 16'h3000;
    @(posedge clk); #1;
    c_req = 0; c_addr = 16'h0000;
    chk("drop_addr_acc", m_addr, 16'h3000);
    chk("drop_en", m_en, 1);
    @(posedge clk); #1;
    chk("drop_ready", c_rdy, 1);
    chk("drop_addr_done", m_addr, 16'h3000);
    @(posedge clk); #1;
    chk("drop_ready_once", c_rdy, 0);
    chk("drop_idle", busy, 0);
    @(posedge clk); #1;
    chk("drop_stay_idle", busy, 0);

    // Round robin after reset: CPU, DBG, CPU, DBG at 3-cycle spacing
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    exp1_q.push_back('{0, 1, 16'h1234});
    exp1_q.push_back('{1, 1, 16'hBEEF});
    exp1_q.push_back('{0, 1, 16'h1234});
    exp1_q.push_back('{1, 1, 16'hBEEF});
    c_req = 1; c_we = 0; c_addr = 16'h3000;
    d_req = 1; d_we = 0; d_addr = 16'h3001;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rr_cpu_k%0d", k), c_rdy, (k == 2 || k == 8));
      chk($sformatf("rr_dbg_k%0d", k), d_ack, (k == 5 || k == 11));
    end
    c_req = 0; d_req = 0;
    @(posedge clk); #1;
    chk("rr_idle", busy, 0);

    // Latency 3 CPU read
    exp3_q.push_back('{0, 1, 16'h1234});
    c3_req = 1; c3_we = 0; c3_addr = 16'h3000;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("l3_en_k%0d", k), m3_en, (k == 1));
      chk($sformatf("l3_busy_k%0d", k), busy3, 1);
      chk($sformatf("l3_rdy_k%0d", k), c3_rdy, (k == 4));
    end
    c3_req = 0;
    @(posedge clk); #1;
    chk("l3_idle", busy3, 0);

    // Reset during WAIT of a debug write
    d3_req = 1; d3_we = 1; d3_addr = 16'h3005; d3_wdata = 16'h5555;
    @(posedge clk); #1;
    chk("rw_acc_we", m3_we, 1);
    @(posedge clk); #1;
    chk("rw_wait", {busy3, m3_en}, 2);
    rst3_n = 0; d3_req = 0;
    @(posedge clk); #1;
    chk("rw_en", {m3_en, m3_we, c3_rdy, d3_ack}, 0);
    chk("rw_gnt", {g3_cpu, g3_dbg, busy3}, 0);
    chk("rw_addr", {m3_addr, m3_wdata}, 0);
    chk("rw_rdata", {c3_rdata, d3_rdata}, 0);
    rst3_n = 1;
    @(posedge clk); #1;
    chk("rw_no_ack", d3_ack, 0);
    exp3_q.push_back('{0, 1, 16'h1234});
    c3_req = 1; c3_we = 0; c3_addr = 16'h3000;
    d3_req = 1; d3_we = 0; d3_addr = 16'h3005;
    @(posedge clk); #1;
    chk("rw_tie_cpu", {g3_cpu, g3_dbg}, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("rw_tie_rdy", c3_rdy, 1);
    c3_req = 0; d3_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb1_drain", exp1_q.size(), 0);
    chk("sb3_drain", exp3_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
